// File: rtl/decode_window_ctrl.sv
// decode_window_ctrl: instruction byte queue and fetch sequencer feeding the
// x86 decoder. Requests aligned 8-byte words, stores the useful bytes in a
// circular buffer and presents a WINDOW_BYTES window starting at decode_pc.
// Optional build macro DECODE_WINDOW_PERF_EN adds stall_cycles and insn_count.
module decode_window_ctrl #(
    parameter int QUEUE_BYTES  = 32,
    parameter int WINDOW_BYTES = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        redirect_valid,
    input  logic [63:0]                 redirect_addr,
    output logic [63:0]                 fetch_addr,
    output logic                        fetch_req,
    input  logic                        fetch_valid,
    input  logic [63:0]                 fetch_data,
    output logic                        fetch_ready,
    output logic [0:8*WINDOW_BYTES-1]   window,
    output logic                        window_valid,
    output logic [63:0]                 decode_pc,
    input  logic                        decode_valid,
    input  logic [3:0]                  decode_bytes
`ifdef DECODE_WINDOW_PERF_EN
    ,
    output logic [31:0]                 stall_cycles,
    output logic [31:0]                 insn_count
`endif
);

    localparam int PW = $clog2(QUEUE_BYTES);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_READY} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [2:0]        skip_q, skip_d;
    logic [63:0]       fetch_addr_q, fetch_addr_d;
    logic [63:0]       decode_pc_q, decode_pc_d;
    logic              fetch_req_q, fetch_req_d;
    logic              window_valid_q, window_valid_d;
    logic [7:0]        mem_q [QUEUE_BYTES];
    logic [7:0]        mem_d [QUEUE_BYTES];

    logic              accept;
    logic              consume;
    logic [CW-1:0]     take;
    logic [CW-1:0]     drop;
    logic [PW-1:0]     wr_idx;

    // Next-state computation: redirect overrides accept and consume.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        head_d         = head_q;
        tail_d         = tail_q;
        skip_d         = skip_q;
        fetch_addr_d   = fetch_addr_q;
        decode_pc_d    = decode_pc_q;
        mem_d          = mem_q;
        wr_idx         = '0;
        accept         = fetch_valid && fetch_req_q;
        consume        = decode_valid && window_valid_q && (decode_bytes != 4'd0);
        take           = accept  ? (CW'(8) - CW'(skip_q)) : '0;
        drop           = consume ? CW'(decode_bytes) : '0;

        if (redirect_valid) begin
            state_d      = ST_FILL;
            count_d      = '0;
            head_d       = '0;
            tail_d       = '0;
            skip_d       = redirect_addr[2:0];
            fetch_addr_d = {redirect_addr[63:3], 3'b000};
            decode_pc_d  = redirect_addr;
        end else begin
            if (accept) begin
                // Bytes below the skip offset precede the redirect target.
                for (int j = 0; j < 8; j++) begin
                    if (3'(j) >= skip_q) begin
                        wr_idx        = tail_q + PW'(j) - PW'(skip_q);
                        mem_d[wr_idx] = fetch_data[8*j +: 8];
                    end
                end
                tail_d       = tail_q + PW'(take);
                skip_d       = 3'd0;
                fetch_addr_d = fetch_addr_q + 64'd8;
            end
            if (consume) begin
                head_d      = head_q + PW'(decode_bytes);
                decode_pc_d = decode_pc_q + 64'(decode_bytes);
            end
            count_d = count_q + take - drop;
            if (state_q == ST_FILL && count_d >= CW'(WINDOW_BYTES)) begin
                state_d = ST_READY;
            end else if (state_q == ST_READY && count_d < CW'(WINDOW_BYTES)) begin
                state_d = ST_FILL;
            end
        end

        fetch_req_d    = (state_d != ST_IDLE) &&
                         (({1'b0, count_d} + (CW+1)'(8)) <= (CW+1)'(QUEUE_BYTES));
        window_valid_d = (state_d == ST_READY);
    end

    // State, queue storage and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            skip_q         <= '0;
            fetch_addr_q   <= '0;
            decode_pc_q    <= '0;
            fetch_req_q    <= 1'b0;
            window_valid_q <= 1'b0;
            for (int i = 0; i < QUEUE_BYTES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            skip_q         <= skip_d;
            fetch_addr_q   <= fetch_addr_d;
            decode_pc_q    <= decode_pc_d;
            fetch_req_q    <= fetch_req_d;
            window_valid_q <= window_valid_d;
            mem_q          <= mem_d;
        end
    end

    // Window byte k is the k-th byte after the head, wrapping around the buffer.
    for (genvar gi = 0; gi < WINDOW_BYTES; gi++) begin : g_window
        assign window[8*gi +: 8] = mem_q[head_q + PW'(gi)];
    end

    assign fetch_addr   = fetch_addr_q;
    assign fetch_req    = fetch_req_q;
    assign fetch_ready  = fetch_req_q;
    assign window_valid = window_valid_q;
    assign decode_pc    = decode_pc_q;

`ifdef DECODE_WINDOW_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] insn_q, insn_d;

    // Saturating counters; only reset clears them, redirects do not.
    always_comb begin
        stall_d = stall_q;
        insn_d  = insn_q;
        if (state_q == ST_FILL && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
        if (consume && !redirect_valid && insn_q != 32'hFFFF_FFFF) begin
            insn_d = insn_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            insn_q  <= '0;
        end else begin
            stall_q <= stall_d;
            insn_q  <= insn_d;
        end
    end

    assign stall_cycles = stall_q;
    assign insn_count   = insn_q;
`endif

endmodule
